uart_tx_arbiter: RTL and testbench

- Shares one 16-bit two-byte UART frame sender between two requesters.
- Requester 0 is the LDPC encoder codeword output path; requester 1 is the status/debug word path.
- Accepts words over valid/ready handshakes and arbitrates round-robin.
- Drives the sender's one-cycle enable and data word, then holds off for a full frame time so the sender is never retriggered mid-frame.

---
 rtl/uart_tx_arbiter.sv | 138 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 16-bit two-byte UART frame sender between
// the LDPC codeword path (req0) and the status/debug path (req1). Each accept
// fires a one-cycle uart_en and then holds off for a full frame time.
// Optional macro UART_ARB_STAT_EN adds per-requester accept counters
// frames0/frames1.
module uart_tx_arbiter #(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned UART_BPS     = 115200,
  parameter int unsigned GUARD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  output logic        uart_en,
  output logic [15:0] uart_din,
  output logic        busy,
  output logic        grant_id
`ifdef UART_ARB_STAT_EN
  ,
  output logic [15:0] frames0,
  output logic [15:0] frames1
`endif
);

  localparam int unsigned DATA_W       = 16;
  localparam int unsigned CNT_W        = 24;
  localparam int unsigned BPS_CNT      = CLK_FREQ / UART_BPS;
  localparam int unsigned FRAME_CYCLES = 21 * BPS_CNT + GUARD_CYCLES;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [DATA_W-1:0]   din_next;
  logic                en_next;
  logic                busy_next;
  logic                grant_next;
  logic                last_grant, last_next;

`ifdef UART_ARB_STAT_EN
  logic [DATA_W-1:0]   frames0_next, frames1_next;
`endif

  // Next-state, arbitration and registered-output next values.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    din_next   = uart_din;
    en_next    = 1'b0;
    grant_next = grant_id;
    last_next  = last_grant;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
`ifdef UART_ARB_STAT_EN
    frames0_next = frames0;
    frames1_next = frames1;
`endif
    case (state)
      IDLE: begin
        // req0 wins unless req1 is also waiting and req0 was served last.
        if (req0_valid && (!req1_valid || last_grant)) begin
          req0_ready = 1'b1;
        end else if (req1_valid) begin
          req1_ready = 1'b1;
        end
        if (req0_ready) begin
          din_next   = req0_data;
          grant_next = 1'b0;
          last_next  = 1'b0;
`ifdef UART_ARB_STAT_EN
          frames0_next = frames0 + DATA_W'(1);
`endif
        end else if (req1_ready) begin
          din_next   = req1_data;
          grant_next = 1'b1;
          last_next  = 1'b1;
`ifdef UART_ARB_STAT_EN
          frames1_next = frames1 + DATA_W'(1);
`endif
        end
        if (req0_ready || req1_ready) begin
          en_next    = 1'b1;
          cnt_next   = CNT_W'(FRAME_CYCLES - 1);
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    busy_next = (state_next == WAIT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      uart_din   <= '0;
      uart_en    <= 1'b0;
      busy       <= 1'b0;
      grant_id   <= 1'b1;
      last_grant <= 1'b1;
`ifdef UART_ARB_STAT_EN
      frames0    <= '0;
      frames1    <= '0;
`endif
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      uart_din   <= din_next;
      uart_en    <= en_next;
      busy       <= busy_next;
      grant_id   <= grant_next;
      last_grant <= last_next;
`ifdef UART_ARB_STAT_EN
      frames0    <= frames0_next;
      frames1    <= frames1_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a frame-level reference model.
// Built with UART_ARB_STAT_EN it also checks the accept counters.
module tb_uart_tx_arbiter;

  localparam int unsigned F       = 214;
  localparam int unsigned SPACING = F + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0;
  logic [15:0] req0_data = 16'h0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [15:0] req1_data = 16'h0;
  logic        req1_ready;
  logic        uart_en;
  logic [15:0] uart_din;
  logic        busy;
  logic        grant_id;
`ifdef UART_ARB_STAT_EN
  logic [15:0] frames0;
  logic [15:0] frames1;
`endif

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .CLK_FREQ    (1000),
    .UART_BPS    (100),
    .GUARD_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .uart_en   (uart_en),
    .uart_din  (uart_din),
    .busy      (busy),
    .grant_id  (grant_id)
`ifdef UART_ARB_STAT_EN
    ,
    .frames0   (frames0),
    .frames1   (frames1)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: frame-time remaining, pointer and last accepted word.
  int          frame_left;
  bit          m_last;
  bit          m_en;
  bit          m_grant;
  logic [15:0] m_din;
  int          acc0;
  int          acc1;

  // Observed/expected: {ready0, ready1, uart_en, busy, grant_id, uart_din}.
  logic [20:0] obs;
  logic [20:0] expv;

  int          en_cycles[$];
  logic [15:0] en_dins[$];
  bit          en_grants[$];

  task automatic model_reset();
    frame_left = 0;
    m_last     = 1'b1;
    m_en       = 1'b0;
    m_grant    = 1'b1;
    m_din      = 16'h0;
    acc0       = 0;
    acc1       = 0;
  endtask

  // Drive one cycle, sample outputs, compute expectation and advance the model.
  task automatic drive_cycle(input bit r, input bit v0, input logic [15:0] d0,
                             input bit v1, input logic [15:0] d1);
    bit e0;
    bit e1;
    @(negedge clk);
    rst        = r;
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    #1;
    obs = {req0_ready, req1_ready, uart_en, busy, grant_id, uart_din};
    e0 = 1'b0;
    e1 = 1'b0;
    if (frame_left == 0) begin
      e0 = v0 && (!v1 || m_last);
      e1 = v1 && (!v0 || !m_last);
    end
    expv = {e0, e1, m_en, (frame_left > 0), m_grant, m_din};
    if (uart_en === 1'b1) begin
      en_cycles.push_back(cyc);
      en_dins.push_back(uart_din);
      en_grants.push_back(grant_id);
    end
    if (r) begin
      model_reset();
    end else if (e0 || e1) begin
      m_din      = e0 ? d0 : d1;
      m_grant    = e1;
      m_last     = e1;
      frame_left = F;
      m_en       = 1'b1;
      if (e0) acc0++;
      else acc1++;
    end else begin
      m_en = 1'b0;
      if (frame_left > 0) frame_left--;
    end
    cyc++;
  endtask

  task automatic do_reset();
    drive_cycle(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    drive_cycle(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    en_cycles.delete();
    en_dins.delete();
    en_grants.delete();
  endtask

  task automatic test_reset();
    do_reset();
    drive_cycle(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    checks++;
    if (obs !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000}) begin
      failures++;
      $display("FAIL reset_state obs=%h exp=%h", obs, {5'b00001, 16'h0000});
    end
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL reset_model obs=%h exp=%h", obs, expv);
    end
  endtask

  task automatic test_single_accept();
    bit seen = 1'b0;
    int busy_cnt = 0;
    int bad_ready = 0;
    do_reset();
    for (int i = 0; i < 230; i++) begin
      drive_cycle(1'b0, !seen, 16'hA55A, 1'b0, 16'h0);
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL single_cycle%0d obs=%h exp=%h", i, obs, expv);
      end
      if (i == 0) begin
        checks++;
        if (obs[20] !== 1'b1) begin
          failures++;
          $display("FAIL single_first_ready got=%b want=1", obs[20]);
        end
      end
      if (i == 1) begin
        checks++;
        if (obs[18:0] !== {1'b1, 1'b1, 1'b0, 16'hA55A}) begin
          failures++;
          $display("FAIL single_pulse got=%h want=%h", obs[18:0], {3'b110, 16'hA55A});
        end
      end
      if (i == 2) begin
        checks++;
        if (obs[18] !== 1'b0) begin
          failures++;
          $display("FAIL single_pulse_width got=%b want=0", obs[18]);
        end
      end
      if (obs[20]) seen = 1'b1;
      if (obs[17] === 1'b1) busy_cnt++;
      if (i >= 1 && obs[17] === 1'b1 && obs[20] !== 1'b0) bad_ready++;
    end
    checks++;
    if (busy_cnt != F) begin
      failures++;
      $display("FAIL single_busy_len got=%0d want=%0d", busy_cnt, F);
    end
    checks++;
    if (bad_ready != 0) begin
      failures++;
      $display("FAIL single_ready_in_wait got=%0d want=0", bad_ready);
    end
  endtask

  task automatic test_contention();
    logic [15:0] seq [4];
    seq[0] = 16'h1111; seq[1] = 16'h2222; seq[2] = 16'h1111; seq[3] = 16'h2222;
    do_reset();
    for (int i = 0; i < 4 * SPACING + 5; i++) begin
      drive_cycle(1'b0, 1'b1, 16'h1111, 1'b1, 16'h2222);
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL contention_cycle%0d obs=%h exp=%h", i, obs, expv);
      end
    end
    checks++;
    if (en_cycles.size() < 4) begin
      failures++;
      $display("FAIL contention_pulses got=%0d want>=4", en_cycles.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (en_dins[k] !== seq[k]) begin
          failures++;
          $display("FAIL contention_din%0d got=%h want=%h", k, en_dins[k], seq[k]);
        end
      end
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (en_cycles[k] - en_cycles[k-1] != SPACING) begin
          failures++;
          $display("FAIL contention_spacing%0d got=%0d want=%0d", k,
                   en_cycles[k] - en_cycles[k-1], SPACING);
        end
      end
    end
  endtask

  task automatic test_single_requester();
    int granted = 0;
    do_reset();
    for (int i = 0; i < 3 * SPACING + 5; i++) begin
      drive_cycle(1'b0, 1'b0, 16'h0, granted < 3, 16'h00FF);
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL solo_cycle%0d obs=%h exp=%h", i, obs, expv);
      end
      if (obs[19]) granted++;
    end
    checks++;
    if (en_cycles.size() != 3) begin
      failures++;
      $display("FAIL solo_pulses got=%0d want=3", en_cycles.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({en_grants[k], en_dins[k]} !== {1'b1, 16'h00FF}) begin
          failures++;
          $display("FAIL solo_word%0d got=%b/%h want=1/00ff", k, en_grants[k], en_dins[k]);
        end
        if (k > 0) begin
          checks++;
          if (en_cycles[k] - en_cycles[k-1] != SPACING) begin
            failures++;
            $display("FAIL solo_spacing%0d got=%0d want=%0d", k,
                     en_cycles[k] - en_cycles[k-1], SPACING);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] d0 = 16'($urandom);
    logic [15:0] d1 = 16'($urandom);
    do_reset();
    for (int i = 0; i < 110; i++) begin
      drive_cycle(i == 101, i == 0, d0, 1'b0, 16'h0);
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL midrst_cycle%0d obs=%h exp=%h", i, obs, expv);
      end
    end
    drive_cycle(1'b0, 1'b1, d0 ^ 16'h5A5A, 1'b1, d1);
    checks++;
    if (obs[20:16] !== 5'b10001) begin
      failures++;
      $display("FAIL midrst_after got=%b want=10001", obs[20:16]);
    end
    drive_cycle(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    checks++;
    if (obs[18:0] !== {1'b1, 1'b1, 1'b0, d0 ^ 16'h5A5A}) begin
      failures++;
      $display("FAIL midrst_regrant got=%h want=%h", obs[18:0], {3'b110, d0 ^ 16'h5A5A});
    end
  endtask

  task automatic test_valid_withdrawn();
    logic [15:0] d0 = 16'($urandom);
    do_reset();
    for (int i = 0; i < SPACING + 20; i++) begin
      drive_cycle(1'b0, i == 0, d0, (i >= 50 && i < 60), 16'($urandom));
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL withdraw_cycle%0d obs=%h exp=%h", i, obs, expv);
      end
    end
    checks++;
    if (en_cycles.size() != 1) begin
      failures++;
      $display("FAIL withdraw_pulses got=%0d want=1", en_cycles.size());
    end
    drive_cycle(1'b0, 1'b1, 16'h0, 1'b1, 16'h0);
    checks++;
    if (obs[20:19] !== 2'b01) begin
      failures++;
      $display("FAIL withdraw_pointer got=%b want=01", obs[20:19]);
    end
  endtask

  task automatic test_random();
    bit h0 = 1'b0;
    bit h1 = 1'b0;
    logic [15:0] d0 = 16'h0;
    logic [15:0] d1 = 16'h0;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (!h0 && $urandom_range(0, 3) == 0) begin
        h0 = 1'b1;
        d0 = 16'($urandom);
      end
      if (!h1 && $urandom_range(0, 5) == 0) begin
        h1 = 1'b1;
        d1 = 16'($urandom);
      end
      drive_cycle(1'b0, h0, d0, h1, d1);
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL random_cycle%0d obs=%h exp=%h", i, obs, expv);
      end
      if (obs[20]) h0 = 1'b0;
      if (obs[19]) h1 = 1'b0;
    end
  endtask

`ifdef UART_ARB_STAT_EN
  task automatic test_stats();
    int n0 = 0;
    int n1 = 0;
    do_reset();
    for (int i = 0; i < 5 * SPACING + 5; i++) begin
      drive_cycle(1'b0, n0 < 3, 16'($urandom), n0 >= 3 && n1 < 2, 16'($urandom));
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL stats_cycle%0d obs=%h exp=%h", i, obs, expv);
      end
      if (obs[20]) n0++;
      if (obs[19]) n1++;
    end
    checks++;
    if ({frames0, frames1} !== {16'(acc0), 16'(acc1)} || acc0 != 3 || acc1 != 2) begin
      failures++;
      $display("FAIL stats_counts got=%0d/%0d want=3/2", frames0, frames1);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_single_accept();
    test_contention();
    test_single_requester();
    test_reset_mid_frame();
    test_valid_withdrawn();
    test_random();
`ifdef UART_ARB_STAT_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
